// File: rtl/oc8051_pt_pkg.sv
// oc8051_pt_pkg: page-table / illegal-access address map and programmer FSM encoding
package oc8051_pt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_REQ = 3'd1,
        LD_GAP = 3'd2,
        DP_REQ = 3'd3,
        DP_GAP = 3'd4,
        FIN    = 3'd5
    } pt_state_e;

    localparam logic [15:0] PT_BASE    = 16'hff80;
    localparam logic [15:0] PT_RD_BASE = 16'hffa0;
    localparam logic [15:0] PT_LAST    = 16'hffbf;
    localparam logic [15:0] IA_BASE    = 16'hffc0;
    localparam logic [15:0] IA_LAST    = 16'hffc5;

    localparam logic [5:0] LD_LAST_BEAT = 6'(PT_LAST - PT_BASE);
    localparam logic [5:0] DP_LAST_BEAT = 6'(IA_LAST - IA_BASE);

    function automatic logic [15:0] beat_addr(input logic [15:0] base, input logic [5:0] beat);
        return base + {10'd0, beat};
    endfunction

endpackage

// File: rtl/oc8051_pt_programmer_if.sv
// oc8051_pt_programmer_if: control, image, XRAM bus and illegal-access capture signals
interface oc8051_pt_programmer_if;

    logic        start_load;
    logic        start_dump;
    logic [5:0]  cfg_idx;
    logic [7:0]  cfg_data;
    logic [15:0] xram_addr;
    logic [7:0]  xram_data_out;
    logic        xram_wr;
    logic        priv_lvl;
    logic        pt_stb;
    logic        pt_ack;
    logic        ia_stb;
    logic        ia_ack;
    logic [7:0]  ia_data_in;
    logic [1:0]  ia_rwn;
    logic [15:0] ia_addr;
    logic [2:0]  ia_src;
    logic [15:0] ia_pc;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start_load, start_dump, cfg_data, pt_ack, ia_ack, ia_data_in,
        output cfg_idx, xram_addr, xram_data_out, xram_wr, priv_lvl, pt_stb, ia_stb,
               ia_rwn, ia_addr, ia_src, ia_pc, busy, done, err
    );

    modport slave (
        output start_load, start_dump, cfg_data, pt_ack, ia_ack, ia_data_in,
        input  cfg_idx, xram_addr, xram_data_out, xram_wr, priv_lvl, pt_stb, ia_stb,
               ia_rwn, ia_addr, ia_src, ia_pc, busy, done, err
    );

endinterface

// File: rtl/oc8051_ack_timer.sv
// oc8051_ack_timer: counts strobe cycles without ack; expired marks the last allowed cycle
module oc8051_ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;
    logic [W-1:0] cur;

    // start is the first strobe cycle, so the count restarts combinationally
    always_comb begin
        cur     = start ? '0 : cnt;
        expired = cur == W'(TIMEOUT - 1);
    end

    always_ff @(posedge clk)
        cnt <= rst || ack ? '0 : expired ? cur : cur + 1'b1;

endmodule

// File: rtl/oc8051_pt_programmer.sv
// oc8051_pt_programmer: writes the 64-byte page table and reads back the 6 illegal-access registers
module oc8051_pt_programmer
    import oc8051_pt_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    oc8051_pt_programmer_if.master bus
);

    pt_state_e  state;
    pt_state_e  state_nxt;
    logic [5:0] beat;
    logic       is_ld;
    logic       is_dp;
    logic       stb_q;
    logic       ack;
    logic       last;
    logic       expired;
    logic       go;

    always_comb begin
        is_ld = state == LD_REQ;
        is_dp = state == DP_REQ;
        ack   = is_ld ? bus.pt_ack : is_dp ? bus.ia_ack : 1'b0;
        last  = beat == (is_ld ? LD_LAST_BEAT : DP_LAST_BEAT);
        go    = state == IDLE && (bus.start_load || bus.start_dump);
    end

    oc8051_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   ((is_ld || is_dp) && !stb_q),
        .ack     (ack),
        .expired (expired)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    // ack wins over a simultaneous timeout expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start_load ? LD_REQ : bus.start_dump ? DP_REQ : IDLE;
            LD_REQ:  state_nxt = ack ? (last ? FIN : LD_GAP) : expired ? IDLE : LD_REQ;
            LD_GAP:  state_nxt = LD_REQ;
            DP_REQ:  state_nxt = ack ? (last ? FIN : DP_GAP) : expired ? IDLE : DP_REQ;
            DP_GAP:  state_nxt = DP_REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat        <= '0;
            stb_q       <= 1'b0;
            bus.err     <= 1'b0;
            bus.ia_rwn  <= '0;
            bus.ia_addr <= '0;
            bus.ia_src  <= '0;
            bus.ia_pc   <= '0;
        end else begin
            stb_q <= is_ld || is_dp;
            if (go)
                beat <= '0;
            else if (ack && !last)
                beat <= beat + 6'd1;
            if (go)
                bus.err <= 1'b0;
            else if ((is_ld || is_dp) && !ack && expired)
                bus.err <= 1'b1;
            if (is_dp && ack)
                case (beat)
                    6'd0:    bus.ia_rwn        <= bus.ia_data_in[1:0];
                    6'd1:    bus.ia_addr[15:8] <= bus.ia_data_in;
                    6'd2:    bus.ia_addr[7:0]  <= bus.ia_data_in;
                    6'd3:    bus.ia_src        <= bus.ia_data_in[2:0];
                    6'd4:    bus.ia_pc[7:0]    <= bus.ia_data_in;
                    6'd5:    bus.ia_pc[15:8]   <= bus.ia_data_in;
                    default: ;
                endcase
        end
    end

    always_comb begin
        bus.pt_stb        = is_ld;
        bus.ia_stb        = is_dp;
        bus.xram_wr       = is_ld;
        bus.xram_addr     = is_ld ? beat_addr(PT_BASE, beat) : is_dp ? beat_addr(IA_BASE, beat) : 16'h0000;
        bus.xram_data_out = is_ld ? bus.cfg_data : 8'h00;
        bus.cfg_idx       = is_ld ? beat : 6'd0;
        bus.busy          = state != IDLE;
        bus.priv_lvl      = state != IDLE;
        bus.done          = state == FIN;
    end

endmodule

// File: tb/tb_oc8051_pt_programmer.sv
// tb_oc8051_pt_programmer: randomized load/dump runs against a transaction-level reference model
module tb_oc8051_pt_programmer;

    localparam int TO = 16;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oc8051_pt_programmer_if bus();

    oc8051_pt_programmer #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  img[64];
    logic [7:0]  bytes[8];
    int          d[64];
    int          hi_cnt = 0;
    logic        noise_en = 1'b0;
    logic        noise_pt = 1'b0;
    logic        noise_ia = 1'b0;
    logic [7:0]  junk = 8'h00;
    logic [23:0] wq[$];
    logic [16:0] rq[$];
    int          run_len;
    int          max_hi;
    int          stab_err;
    logic        prev_stb = 1'b0;
    logic [24:0] prev = '0;
    logic [1:0]  e_rwn = '0;
    logic [15:0] e_addr = '0;
    logic [2:0]  e_src = '0;
    logic [15:0] e_pc = '0;

    // responder: acks after d[beat] extra strobe cycles, garbage acks/data when idle
    always_comb begin
        bus.cfg_data   = img[bus.cfg_idx];
        bus.pt_ack     = bus.pt_stb ? hi_cnt >= d[bus.xram_addr[5:0]] : noise_pt;
        bus.ia_ack     = bus.ia_stb ? hi_cnt >= d[bus.xram_addr[2:0]] : noise_ia;
        bus.ia_data_in = bus.ia_stb ? bytes[bus.xram_addr[2:0]] : junk;
    end

    always @(posedge clk)
        hi_cnt <= (bus.pt_stb || bus.ia_stb) ? hi_cnt + 1 : 0;

    function automatic logic [36:0] outs_a();
        return {bus.cfg_idx, bus.xram_addr, bus.xram_data_out, bus.xram_wr, bus.priv_lvl,
                bus.pt_stb, bus.ia_stb, bus.busy, bus.done, bus.err};
    endfunction

    function automatic logic [36:0] outs_b();
        return {bus.ia_rwn, bus.ia_addr, bus.ia_src, bus.ia_pc};
    endfunction

    task automatic sample();
        logic stb;
        stb = bus.pt_stb || bus.ia_stb;
        if (bus.pt_stb && bus.pt_ack) wq.push_back({bus.xram_addr, bus.xram_data_out});
        if (bus.ia_stb && bus.ia_ack) rq.push_back({bus.xram_addr, bus.xram_wr});
        if (stb && prev_stb && {bus.xram_addr, bus.xram_data_out, bus.xram_wr} != prev) stab_err++;
        prev_stb = stb;
        prev = {bus.xram_addr, bus.xram_data_out, bus.xram_wr};
        run_len = stb ? run_len + 1 : 0;
        if (run_len > max_hi) max_hi = run_len;
        noise_pt = noise_en & 1'($urandom_range(1));
        noise_ia = noise_en & 1'($urandom_range(1));
        junk = 8'($urandom);
    endtask

    task automatic run_op(input string nm, input bit ld, input bit both, input int fail_beat, output int done_at);
        int nb, k, exp_busy, exp_max, busy_cnt, done_cnt;
        bit fin;
        nb = ld ? 64 : 6;
        k = fail_beat >= 0 ? fail_beat : nb;
        if (fail_beat >= 0) d[fail_beat] = NEVER;
        exp_busy = 0;
        exp_max = 0;
        for (int i = 0; i < k; i++) begin
            exp_busy += d[i] + 2;
            if (d[i] + 1 > exp_max) exp_max = d[i] + 1;
        end
        if (k != nb) begin
            exp_busy += TO;
            if (TO > exp_max) exp_max = TO;
        end
        wq.delete();
        rq.delete();
        run_len = 0;
        max_hi = 0;
        stab_err = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at = 0;
        fin = 0;
        @(negedge clk);
        sample();
        bus.start_load = ld || both;
        bus.start_dump = !ld || both;
        for (int n = 1; n <= 20000; n++) begin
            @(negedge clk);
            sample();
            bus.start_load = n == 3;
            bus.start_dump = n == 3;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = n;
            end
            if (!bus.busy) begin
                fin = 1;
                break;
            end
        end
        bus.start_load = 1'b0;
        bus.start_dump = 1'b0;
        chk({nm, "_finish"}, 64'(fin), 1);
        chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'(k == nb));
        chk({nm, "_done_at"}, 64'(done_at), k == nb ? 64'(exp_busy) : 64'd0);
        chk({nm, "_err"}, 64'(bus.err), 64'(k != nb));
        chk({nm, "_max_stb"}, 64'(max_hi), 64'(exp_max));
        chk({nm, "_stable"}, 64'(stab_err), 0);
        chk({nm, "_wr_n"}, 64'(wq.size()), ld ? 64'(k) : 64'd0);
        chk({nm, "_rd_n"}, 64'(rq.size()), ld ? 64'd0 : 64'(k));
        for (int i = 0; i < wq.size() && i < 64; i++)
            chk($sformatf("%s_wr%0d", nm, i), 64'(wq[i]), 64'({16'hff80 + 16'(i), img[i]}));
        for (int i = 0; i < rq.size() && i < 6; i++)
            chk($sformatf("%s_rd%0d", nm, i), 64'(rq[i]), 64'({16'hffc0 + 16'(i), 1'b0}));
        if (!ld)
            for (int i = 0; i < k; i++)
                case (i)
                    0: e_rwn = bytes[0][1:0];
                    1: e_addr[15:8] = bytes[1];
                    2: e_addr[7:0] = bytes[2];
                    3: e_src = bytes[3][2:0];
                    4: e_pc[7:0] = bytes[4];
                    default: e_pc[15:8] = bytes[5];
                endcase
        chk({nm, "_ia_rwn"}, 64'(bus.ia_rwn), 64'(e_rwn));
        chk({nm, "_ia_addr"}, 64'(bus.ia_addr), 64'(e_addr));
        chk({nm, "_ia_src"}, 64'(bus.ia_src), 64'(e_src));
        chk({nm, "_ia_pc"}, 64'(bus.ia_pc), 64'(e_pc));
    endtask

    task automatic fill(input int dmax, input bit rnd);
        for (int i = 0; i < 64; i++) begin
            d[i] = dmax < 0 ? ($urandom_range(3) == 0 ? TO - 1 : int'($urandom_range(4))) : dmax;
            img[i] = rnd ? 8'($urandom) : 8'(i) ^ 8'h5a;
        end
        for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
    endtask

    initial begin
        int da;
        bit found;
        bus.start_load = 1'b0;
        bus.start_dump = 1'b0;
        fill(0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_a", 64'(outs_a()), 0);
        chk("reset_b", 64'(outs_b()), 0);

        run_op("load_imm", 1, 0, -1, da);
        chk("load_done_128", 64'(da), 128);

        fill(2, 0);
        bytes[0] = 8'h02; bytes[1] = 8'h12; bytes[2] = 8'h34;
        bytes[3] = 8'h05; bytes[4] = 8'h78; bytes[5] = 8'h56;
        run_op("dump_d2", 0, 0, -1, da);
        chk("dump_val", 64'(outs_b()), 64'({2'd2, 16'h1234, 3'd5, 16'h5678}));

        fill(0, 1);
        run_op("load_abort10", 1, 0, 10, da);

        fill(1, 1);
        run_op("both_start", 1, 1, -1, da);

        fill(TO - 1, 1);
        run_op("dump_ack16", 0, 0, -1, da);
        fill(0, 1);
        d[7] = TO - 1;
        run_op("load_ack16", 1, 0, -1, da);

        fill(1, 1);
        run_op("dump_abort3", 0, 0, 3, da);

        fill(0, 1);
        found = 0;
        @(negedge clk);
        sample();
        bus.start_load = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            sample();
            bus.start_load = 1'b0;
            if (bus.pt_stb && bus.xram_addr == 16'hff9e) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_beat30", 64'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_a", 64'(outs_a()), 0);
        chk("rst_mid_b", 64'(outs_b()), 0);
        e_rwn = '0; e_addr = '0; e_src = '0; e_pc = '0;
        @(negedge clk);
        chk("rst_idle", 64'(outs_a()), 0);
        run_op("load_after_rst", 1, 0, -1, da);

        noise_en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            bit ld;
            bit both;
            int fb;
            ld = 1'($urandom_range(1));
            both = ld && $urandom_range(3) == 0;
            fb = $urandom_range(4) == 0 ? int'($urandom_range(ld ? 63 : 5)) : -1;
            fill(-1, 1);
            run_op($sformatf("rnd%0d", t), ld, both, fb, da);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
